// File: rtl/multdiv_unit.sv
// Iterative signed multiply/divide unit for the execute stage.
// A start strobe sampled in IDLE or DONE captures the operands; the unit then
// runs WIDTH iterations and pulses data_resultRDY for one cycle with the result.
// The multiply is a radix-2 Booth sequence. The divide is a restoring division
// on operand magnitudes, with the quotient sign fixed up at the end.
//
// Ports:
//   clock          rising-edge clock
//   reset          synchronous active-low reset
//   ctrl_MULT      start-multiply strobe (wins over ctrl_DIV)
//   ctrl_DIV       start-divide strobe
//   data_operandA  multiplicand / dividend, two's complement
//   data_operandB  multiplier / divisor, two's complement
//   data_result    product low word or quotient, held until the next completion
//   data_exception signed overflow or divide-by-zero, valid with data_resultRDY
//   data_resultRDY one-cycle completion pulse
//   busy           stall request while an operation is iterating
module multdiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int unsigned      CNT_W   = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    // acc carries one guard bit so that subtracting the most negative
    // multiplicand cannot overflow; in divide mode it holds the remainder.
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] q;        // multiplier bits / dividend-then-quotient
    logic [WIDTH-1:0] m;        // multiplicand / divisor magnitude
    logic             q_m1;     // Booth look-behind bit
    logic             div_neg;
    logic             div_zero;
    logic             div_ovf;

    // Divide start values derived from the live operands
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic             start_div_zero;
    logic             start_div_ovf;

    assign abs_a          = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign abs_b          = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    assign start_div_zero = (data_operandB == '0);
    assign start_div_ovf  = (data_operandA == MIN_VAL) && (&data_operandB);

    // One iteration of each algorithm, plus the final result shaping
    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_trial;
    logic [WIDTH:0]   prod_hi;
    logic             mul_ovf;
    logic [WIDTH-1:0] div_q_signed;

    always_comb begin
        booth_sum = acc;
        case ({q[0], q_m1})
            2'b01:   booth_sum = acc + {m[WIDTH-1], m};
            2'b10:   booth_sum = acc - {m[WIDTH-1], m};
            default: booth_sum = acc;
        endcase
        div_shift    = {acc[WIDTH-1:0], q[WIDTH-1]};
        div_trial    = div_shift - {1'b0, m};
        // Bits [2W-1:W-1] of the product must be a pure sign extension
        prod_hi      = {acc[WIDTH-1:0], q[WIDTH-1]};
        mul_ovf      = ~((&prod_hi) | ~(|prod_hi));
        div_q_signed = div_neg ? -q : q;
    end

    // Sequencer, datapath and registered outputs
    always_ff @(posedge clock) begin
        if (!reset) begin
            state          <= IDLE;
            cnt            <= '0;
            acc            <= '0;
            q              <= '0;
            m              <= '0;
            q_m1           <= 1'b0;
            div_neg        <= 1'b0;
            div_zero       <= 1'b0;
            div_ovf        <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    busy <= 1'b0;
                    if (ctrl_MULT) begin
                        state <= MUL;
                        cnt   <= '0;
                        acc   <= '0;
                        q     <= data_operandB;
                        q_m1  <= 1'b0;
                        m     <= data_operandA;
                    end else if (ctrl_DIV) begin
                        state    <= DIV;
                        cnt      <= '0;
                        acc      <= '0;
                        q        <= abs_a;
                        q_m1     <= 1'b0;
                        m        <= abs_b;
                        div_neg  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                        div_zero <= start_div_zero;
                        div_ovf  <= start_div_ovf;
                    end else begin
                        state <= IDLE;
                    end
                end
                MUL: begin
                    if (cnt != LAST) begin
                        busy <= 1'b1;
                        cnt  <= cnt + CNT_W'(1);
                        // Add/subtract, then arithmetic shift of {acc, q, q_m1}
                        acc  <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
                        q    <= {booth_sum[0], q[WIDTH-1:1]};
                        q_m1 <= q[0];
                    end else begin
                        state          <= DONE;
                        busy           <= 1'b0;
                        data_resultRDY <= 1'b1;
                        data_result    <= q;
                        data_exception <= mul_ovf;
                    end
                end
                DIV: begin
                    if (cnt != LAST) begin
                        busy <= 1'b1;
                        cnt  <= cnt + CNT_W'(1);
                        // Keep the trial difference only when it is non-negative
                        if (!div_trial[WIDTH]) begin
                            acc <= div_trial;
                            q   <= {q[WIDTH-2:0], 1'b1};
                        end else begin
                            acc <= div_shift;
                            q   <= {q[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        state          <= DONE;
                        busy           <= 1'b0;
                        data_resultRDY <= 1'b1;
                        data_result    <= div_zero ? '0 : div_q_signed;
                        data_exception <= div_zero | div_ovf;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit: directed cases with literal
// expectations, then randomized strobes/operands/resets against an
// arithmetic reference model checked every cycle.
module tb_multdiv_unit;

    localparam int W = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          ctrl_MULT = 1'b0;
    logic          ctrl_DIV = 1'b0;
    logic [W-1:0]  op_a = '0;
    logic [W-1:0]  op_b = '0;
    logic [W-1:0]  data_result;
    logic          data_exception;
    logic          data_resultRDY;
    logic          busy;

    multdiv_unit #(.WIDTH(W)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (op_a),
        .data_operandB  (op_b),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Arithmetic reference: what a finished operation must report
    function automatic void calc(input bit is_mul, input logic [W-1:0] x, input logic [W-1:0] y,
                                 output logic [W-1:0] r, output logic e);
        longint p;
        int     sx;
        int     sy;
        sx = $signed(x);
        sy = $signed(y);
        if (is_mul) begin
            p = longint'(sx) * longint'(sy);
            r = p[31:0];
            e = (p != longint'($signed(p[31:0])));
        end else if (y == 32'h0) begin
            r = '0;
            e = 1'b1;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            r = 32'h8000_0000;
            e = 1'b1;
        end else begin
            r = 32'(sx / sy);
            e = 1'b0;
        end
    endfunction

    // Timing model: an op accepted at edge s is busy after edges s+1..s+W,
    // completes after edge s+W+1, and a new op may be accepted from edge s+W+2.
    int           edge_n  = 0;
    int           s_edge  = 0;
    bit           pend    = 0;
    bit           started = 0;
    logic [W-1:0] res_next = '0;
    logic         exc_next = 1'b0;
    logic [W-1:0] exp_res  = '0;
    logic         exp_exc  = 1'b0;
    logic         exp_rdy  = 1'b0;
    logic         exp_busy = 1'b0;

    always @(posedge clock) begin
        started = 1;
        edge_n++;
        if (!reset) begin
            pend     = 0;
            exp_res  = '0;
            exp_exc  = 1'b0;
            exp_rdy  = 1'b0;
            exp_busy = 1'b0;
        end else begin
            if (pend && edge_n == s_edge + W + 1) begin
                exp_res = res_next;
                exp_exc = exc_next;
            end
            if ((!pend || edge_n >= s_edge + W + 2) && (ctrl_MULT || ctrl_DIV)) begin
                pend   = 1;
                s_edge = edge_n;
                calc(ctrl_MULT, op_a, op_b, res_next, exc_next);
            end
            exp_rdy  = pend && (edge_n == s_edge + W + 1);
            exp_busy = pend && (edge_n >= s_edge + 1) && (edge_n <= s_edge + W);
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clock) begin
        if (started) begin
            check($sformatf("rdy@%0d", edge_n),    64'(data_resultRDY), 64'(exp_rdy));
            check($sformatf("busy@%0d", edge_n),   64'(busy),           64'(exp_busy));
            check($sformatf("result@%0d", edge_n), 64'(data_result),    64'(exp_res));
            check($sformatf("exc@%0d", edge_n),    64'(data_exception), 64'(exp_exc));
        end
    end

    // Strobe is already driven for the current cycle; release it and wait
    task automatic finish_op(input string nm, input logic [W-1:0] want_r, input logic want_e);
        int  n;
        int  nb;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        n  = 0;
        nb = 0;
        while (n < 60) begin
            @(negedge clock);
            n++;
            if (busy) nb++;
            if (data_resultRDY) break;
        end
        check({nm, "_latency"}, 64'(n), 64'(W + 1));
        check({nm, "_busy_cycles"}, 64'(nb), 64'(W));
        check({nm, "_result"}, 64'(data_result), 64'(want_r));
        check({nm, "_exc"}, 64'(data_exception), 64'(want_e));
    endtask

    task automatic run_op(input bit mul, input bit dv, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] want_r, input logic want_e, input string nm);
        ctrl_MULT = mul;
        ctrl_DIV  = dv;
        op_a      = x;
        op_b      = y;
        finish_op(nm, want_r, want_e);
    endtask

    function automatic logic [W-1:0] rand_op();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 200)) - 32'd100;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int rdys;
        int rdy_at;

        repeat (3) @(negedge clock);
        check("reset_result", 64'(data_result), 64'h0);
        check("reset_busy", 64'(busy), 64'h0);
        check("reset_rdy", 64'(data_resultRDY), 64'h0);
        reset = 1'b1;
        @(negedge clock);

        run_op(1, 0, 32'd7, 32'hFFFF_FFFA, 32'hFFFF_FFD6, 1'b0, "mul_7_m6");
        run_op(1, 0, 32'h0001_0000, 32'h0001_0000, 32'h0, 1'b1, "mul_ovf");
        run_op(1, 0, 32'h7FFF_FFFF, 32'd1, 32'h7FFF_FFFF, 1'b0, "mul_max");
        run_op(1, 0, 32'h8000_0000, 32'h8000_0000, 32'h0, 1'b1, "mul_min_min");
        run_op(0, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, "div_m7_2");
        run_op(0, 1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, "div_7_m2");
        run_op(0, 1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 1'b0, "div_m7_m2");
        run_op(0, 1, 32'd100, 32'd7, 32'd14, 1'b0, "div_100_7");
        run_op(0, 1, 32'd5, 32'd0, 32'h0, 1'b1, "div_by_zero");
        run_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "div_wrap");
        run_op(0, 1, 32'd0, 32'd5, 32'h0, 1'b0, "div_zero_dividend");

        // Strobe and operand changes while busy are ignored
        ctrl_DIV = 1'b1;
        op_a     = 32'd100;
        op_b     = 32'd7;
        @(negedge clock);
        ctrl_DIV = 1'b0;
        rdys     = 0;
        rdy_at   = 0;
        for (int i = 1; i <= W + 1; i++) begin
            @(negedge clock);
            ctrl_MULT = (i == 10);
            if (i == 10) begin
                op_a = $urandom;
                op_b = $urandom;
            end
            if (data_resultRDY) begin
                rdys++;
                rdy_at = i;
            end
        end
        check("busy_strobe_rdy_count", 64'(rdys), 64'd1);
        check("busy_strobe_rdy_at", 64'(rdy_at), 64'(W + 1));
        check("busy_strobe_result", 64'(data_result), 64'd14);

        // New strobe in the DONE cycle starts immediately
        ctrl_MULT = 1'b1;
        op_a      = 32'd6;
        op_b      = 32'd3;
        finish_op("back_to_back", 32'd18, 1'b0);

        // Reset in the middle of a multiply discards it
        ctrl_MULT = 1'b1;
        op_a      = 32'd123;
        op_b      = 32'd456;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        repeat (15) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("midreset_result", 64'(data_result), 64'h0);
        check("midreset_exc", 64'(data_exception), 64'h0);
        check("midreset_busy", 64'(busy), 64'h0);
        check("midreset_rdy", 64'(data_resultRDY), 64'h0);
        reset = 1'b1;
        rdys  = 0;
        repeat (40) begin
            @(negedge clock);
            if (data_resultRDY) rdys++;
        end
        check("midreset_no_rdy", 64'(rdys), 64'd0);

        run_op(1, 1, 32'd6, 32'd3, 32'd18, 1'b0, "both_strobes");

        // Randomized traffic: strobes at any time, operands changing every cycle
        for (int c = 0; c < 3000; c++) begin
            reset     = ($urandom_range(0, 399) != 0);
            ctrl_MULT = ($urandom_range(0, 5) == 0);
            ctrl_DIV  = ($urandom_range(0, 5) == 0);
            op_a      = rand_op();
            op_b      = rand_op();
            @(negedge clock);
        end
        reset     = 1'b1;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        repeat (40) @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multdiv_unit.md
Name: multdiv_unit

Overview:
- Iterative signed 32-bit multiply/divide unit in the execute stage.
- Sits directly downstream of the instruction decoder. It consumes the decoded mul/div strobes and the two register-file operands, and returns the result plus an exception flag for the $rstatus writeback path.
- Multi-cycle. The pipeline stalls on busy and resumes on data_resultRDY.

Parameters:
- WIDTH, 32, operand/result width. The iteration counter is clog2(WIDTH)+1 bits.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset (sampled on clock rising edge; 0 = reset)
- ctrl_MULT  input  1  start-multiply strobe, sampled each cycle
- ctrl_DIV  input  1  start-divide strobe, sampled each cycle
- data_operandA  input  WIDTH  multiplicand / dividend (rs), two's complement
- data_operandB  input  WIDTH  multiplier / divisor (rt), two's complement
- data_result  output  WIDTH  product low word or quotient
- data_exception  output  1  overflow or divide-by-zero, valid with data_resultRDY
- data_resultRDY  output  1  one-cycle completion pulse
- busy  output  1  high while an operation is in flight (stall request)

Behaviour:
- States: IDLE, MUL, DIV, DONE. Reset value: IDLE.
- Reset (reset=0 at a clock edge), including mid-operation: state goes to IDLE. data_result=0, data_exception=0, data_resultRDY=0, busy=0, counter=0. Any in-flight operation is discarded with no RDY pulse.
- Start: in IDLE or DONE, ctrl_MULT=1 at edge N latches A and B, clears the counter and enters MUL. ctrl_DIV=1 does the same and enters DIV.
  - If both strobes are high, MULT wins.
  - Strobes sampled in MUL or DIV are ignored: no queuing, no restart.
- busy: 1 in MUL and DIV only. It rises the cycle after edge N and is 0 in DONE.
- Iterations: one per cycle, exactly WIDTH cycles. The counter counts 0..WIDTH-1, then the state goes to DONE.
- DONE lasts one cycle:
  - data_resultRDY=1, data_result and data_exception take their final values.
  - Next state is IDLE, or MUL/DIV if a new strobe is sampled in DONE (back-to-back allowed).
- Latency: data_resultRDY is high exactly in the cycle following edge N+WIDTH+1, i.e. WIDTH+1 cycles after the start cycle.
- data_result and data_exception hold their values after DONE until the next DONE or reset. data_resultRDY is 0 outside DONE.
- Multiply:
  - Radix-2 Booth, 2*WIDTH+1-bit product/multiplier register, arithmetic right shift per iteration.
  - data_result = product[WIDTH-1:0].
  - data_exception=1 iff product[2*WIDTH-1:WIDTH-1] is not all 0s or all 1s (signed overflow).
- Divide:
  - Non-restoring or restoring on magnitudes |A| and |B|.
  - Quotient negated iff sign(A) xor sign(B). Truncation is toward zero; the remainder is discarded.
  - B=0: data_result=0, data_exception=1, same WIDTH+1 latency (no early exit).
  - A=-2^(WIDTH-1), B=-1: data_result=0x80000000 (wrap), data_exception=1.
  - A=0: data_result=0, exception=0.
- Operands are captured only at start. Changes on data_operandA/B during MUL or DIV have no effect.

Test Plan:
- Reset, then ctrl_MULT pulse with A=7, B=-6:
  - busy=1 for 32 cycles.
  - RDY exactly 33 cycles after the strobe, with data_result=0xFFFFFFD6 (-42), exception=0.
- ctrl_MULT with A=0x00010000, B=0x00010000 -> data_result=0x00000000, exception=1. Then A=0x7FFFFFFF, B=1 -> 0x7FFFFFFF, exception=0.
- ctrl_DIV, four sign cases, each -> exception=0:
  - A=-7, B=2 -> data_result=0xFFFFFFFD (-3).
  - A=7, B=-2 -> -3.
  - A=-7, B=-2 -> 3.
  - A=100, B=7 -> 14.
- ctrl_DIV with A=5, B=0 -> result 0, exception=1 after 33 cycles. Then A=0x80000000, B=-1 -> result 0x80000000, exception=1.
- Strobe while busy: start DIV 100/7, pulse ctrl_MULT at cycle +10 and change operands mid-op -> single RDY at +33 with result 14, no second RDY. Strobe in the DONE cycle -> new op's RDY 33 cycles later.
- Assert reset=0 at cycle +15 of a MUL -> next cycle: all outputs 0, state IDLE, no RDY pulse. Simultaneous ctrl_MULT and ctrl_DIV with A=6, B=3 -> result 18 (multiply wins).
